// File: rtl/key_evt_pkg.sv
// Shared types for the key event decoder.
//   state_t    : gesture classifier states
//   evt_code_t : coded event bus values (press/release are not coded)
//   EVT_CODE_W : width of the coded event bus
package key_evt_pkg;

  localparam int unsigned EVT_CODE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD,
    ST_WAIT_GAP,
    ST_WAIT_RELEASE
  } state_t;

  typedef enum logic [EVT_CODE_W-1:0] {
    EVT_NONE   = 3'd0,
    EVT_SHORT  = 3'd1,
    EVT_LONG   = 3'd2,
    EVT_DOUBLE = 3'd3,
    EVT_REPEAT = 3'd4
  } evt_code_t;

endpackage

// File: rtl/key_event_decoder_edge_detect.sv
// Registered-level edge detector, reusable by any key consumer.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset; history loads RESET_VAL
//   level in  clk-synchronous level
//   rise  out level & ~previous level (combinational)
//   fall  out ~level & previous level (combinational)
// RESET_VAL = 1 makes a level held through reset look "already high",
// so it produces no rise after reset.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_d;

  always_ff @(posedge clk) begin
    if (rst) level_d <= RESET_VAL;
    else     level_d <= level;
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/key_event_decoder.sv
// Key gesture classifier: turns a debounced key level into one-cycle
// press/release/short/long/double-click (and optional repeat) pulses,
// plus a coded event bus for a single downstream consumer.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   key_in         debounced key level, 1 = pressed
//   press_pulse    pulse on every accepted rising edge
//   release_pulse  pulse on every accepted falling edge
//   short_press    single press/release, no second press in the gap window
//   long_press     hold reached LONG_CYCLES
//   double_click   second press within the gap window
//   repeat_pulse   auto-repeat while long-held (0 unless KEY_REPEAT_EN)
//   event_valid    event_code valid this cycle
//   event_code     0 none, 1 short, 2 long, 3 double, 4 repeat
// Optional feature macro: KEY_REPEAT_EN (auto-repeat in LONG_HELD).
// All outputs are registered: an edge sampled at clock N shows in cycle N+1.
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int unsigned LONG_CYCLES       = 50_000_000,
  parameter int unsigned DOUBLE_GAP_CYCLES = 15_000_000,
  parameter int unsigned REPEAT_CYCLES     = 10_000_000,
  parameter int unsigned CNT_W             = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic       repeat_pulse,
  output logic       event_valid,
  output logic [2:0] event_code
);

  if (LONG_CYCLES < 2 || DOUBLE_GAP_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("key_event_decoder: cycle parameters must be >= 2");
  end

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic       rise, fall;
  state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic       short_n, long_n, double_n, repeat_n;
  logic       valid_n;
  evt_code_t  code_n;

  edge_detect #(.RESET_VAL(1'b1)) u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (key_in),
    .rise  (rise),
    .fall  (fall)
  );

  // Edge priority inside each state resolves the same-cycle races:
  // fall beats long terminal count, rise beats gap terminal count,
  // fall beats repeat terminal count.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;
    repeat_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_n = ST_PRESSED;
          cnt_n   = '0;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          state_n = ST_WAIT_GAP;
          cnt_n   = '0;
        end else if (cnt == LONG_TERM) begin
          long_n  = 1'b1;
          state_n = ST_LONG_HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (fall) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (cnt == REP_TERM) begin
          repeat_n = 1'b1;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      ST_WAIT_GAP: begin
        if (rise) begin
          double_n = 1'b1;
          state_n  = ST_WAIT_RELEASE;
          cnt_n    = '0;
        end else if (cnt == GAP_TERM) begin
          short_n = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_WAIT_RELEASE: begin
        if (fall) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    code_n = EVT_NONE;
    if (short_n)       code_n = EVT_SHORT;
    else if (long_n)   code_n = EVT_LONG;
    else if (double_n) code_n = EVT_DOUBLE;
    else if (repeat_n) code_n = EVT_REPEAT;
    valid_n = short_n | long_n | double_n | repeat_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
      event_valid   <= 1'b0;
      event_code    <= EVT_NONE;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_press   <= short_n;
      long_press    <= long_n;
      double_click  <= double_n;
      event_valid   <= valid_n;
      event_code    <= code_n;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) repeat_pulse <= 1'b0;
    else     repeat_pulse <= repeat_n;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
